nibble_add_sched: RTL

- Sequencer and arbiter that shares one external 4-bit ripple-carry adder slice between two requesters.
- Each request is a WIDTH-bit add. The block feeds the shared slice one nibble per cycle, LSB nibble first, and chains the carry through a register.
- The result is returned on a valid/ready response channel tagged with the requester id.
- It sits between client logic and the single adder instance, so WIDTH-bit adds run without replicating the adder.

---
 rtl/nibble_add_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_add_sched.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add_sched
//  Description : Shares one external 4-bit ripple-carry adder slice between
//                two requesters. Each WIDTH-bit add is fed to the slice one
//                nibble per cycle, LSB nibble first, with the carry chained
//                through a register. The result comes back on a valid/ready
//                response channel tagged with the requester id.
//
//  Ports       :
//    clk, rst_n                 clock (rising edge), async active-low reset
//    req{0,1}_valid/_ready      request handshake per requester
//    req{0,1}_a/_b/_cin         WIDTH-bit operands and carry-in
//    rsp_valid/rsp_ready        response handshake
//    rsp_id/rsp_sum/rsp_cout    owning requester, sum, final carry-out
//    add_a/add_b/add_c0         nibble operands and carry to the shared slice
//    add_sum/add_cout           combinational result from the shared slice
//
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,

    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_c0,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              prio;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic              id;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  result;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              last_nib;
    logic [WIDTH-1:0]  a_shift;
    logic [WIDTH-1:0]  b_shift;

    // Requester 1 wins when it is alone, or on a tie when prio points at it.
    assign grant1   = req1_valid & (~req0_valid | prio);
    assign grant0   = req0_valid & ~grant1;

    assign last_nib = (idx == IDXW'(NIB - 1));

    // Bring the current nibble down to bit 0 rather than using a variable
    // part-select on the read side.
    assign a_shift  = opa >> {idx, 2'b00};
    assign b_shift  = opb >> {idx, 2'b00};

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = result;
    assign rsp_cout  = carry;
    assign rsp_id    = id;

    // ------------------------------------------------------------------
    // Next state, handshake and adder-slice drive
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_c0     = 1'b0;

        case (state)
            IDLE: begin
                // Gating with rst_n keeps ready low while reset is held even
                // if a requester is already presenting valid.
                req0_ready = rst_n & grant0;
                req1_ready = rst_n & grant1;
                accept     = req0_ready | req1_ready;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_a  = a_shift[3:0];
                add_b  = b_shift[3:0];
                add_c0 = carry;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            prio   <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            id     <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= '0;
                        id  <= grant1;
                        if (grant1) begin
                            opa   <= req1_a;
                            opb   <= req1_b;
                            carry <= req1_cin;
                        end else begin
                            opa   <= req0_a;
                            opb   <= req0_b;
                            carry <= req0_cin;
                        end
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= add_sum;
                    carry                     <= add_cout;
                    idx                       <= idx + IDXW'(1);
                end
                DONE: begin
                    // The requester just served loses the next tie.
                    if (rsp_ready) begin
                        prio <= ~id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
